// File: rtl/uart_row_loader.sv
// UART row loader: parses A5/row/pixel packets into frame-RAM writes and answers ACK/NAK.
// Optional trailing checksum byte is enabled by defining UART_ROW_LOADER_CHECKSUM_EN.
module uart_row_loader #(
    parameter int WIDTH          = 640,
    parameter int HEIGHT         = 480,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        ram_wr,
    output logic [18:0] ram_addr,
    output logic [2:0]  ram_data,
    output logic        ans_valid,
    output logic [7:0]  ans_data,
    input  logic        ans_ready,
    output logic        row_done,
    output logic        overflow
);

    localparam int              NBYTES   = WIDTH / 2;
    localparam int              CW       = $clog2(NBYTES + 1);
    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NBYTES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]      HGT      = 10'(HEIGHT);
    localparam logic [18:0]     WID      = 19'(WIDTH);
    localparam logic [7:0]      ACK      = 8'h06;
    localparam logic [7:0]      NAK      = 8'h15;

    typedef enum logic [2:0] {IDLE, ROW_HI, ROW_LO, PIX, WR0, WR1, ANSWER} state_e;

    state_e        state_q, state_d;
    logic          row8_q, row8_d;
    logic [18:0]   base_q, base_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    hi_q, hi_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic [7:0]    chk_q, chk_d;
    logic          ram_wr_q, ram_wr_d;
    logic [18:0]   ram_addr_q, ram_addr_d;
    logic [2:0]    ram_data_q, ram_data_d;
    logic          ans_valid_q, ans_valid_d;
    logic [7:0]    ans_data_q, ans_data_d;
    logic          row_done_q, row_done_d;
    logic          ovf_q, ovf_d;

    logic          take;
    logic [7:0]    take_byte;
    logic [8:0]    row_full;
    logic          expired;
    logic          go_ans, go_done;
    logic [7:0]    go_code;

    assign row_full = {row8_q, rx_data};
    assign expired  = (tmo_q == TMO_LAST);

    // In WR1 a held byte has priority; otherwise a byte arriving right now is used directly.
    always_comb begin
        take      = 1'b0;
        take_byte = rx_data;
        if (state_q == PIX) begin
            take = rx_valid;
        end else if (state_q == WR1) begin
            take = hold_vld_q | rx_valid;
            if (hold_vld_q) take_byte = hold_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        row8_d      = row8_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        hi_d        = hi_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        chk_d       = chk_q;
        ram_wr_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ans_valid_d = ans_valid_q;
        ans_data_d  = ans_data_q;
        row_done_d  = 1'b0;
        ovf_d       = ovf_q;
        go_ans      = 1'b0;
        go_code     = NAK;
        go_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == 8'hA5) state_d = ROW_HI;
            end
            ROW_HI: begin
                if (rx_valid) begin
                    row8_d  = rx_data[0];
                    chk_d   = rx_data;
                    state_d = ROW_LO;
                end else begin
                    tmo_d  = tmo_q + TW'(1);
                    go_ans = expired;
                end
            end
            ROW_LO: begin
                if (rx_valid) begin
                    chk_d = chk_q ^ rx_data;
                    if ({1'b0, row_full} >= HGT) begin
                        go_ans = 1'b1;
                    end else begin
                        base_d  = 19'(row_full) * WID;
                        cnt_d   = '0;
                        state_d = PIX;
                    end
                end else begin
                    tmo_d  = tmo_q + TW'(1);
                    go_ans = expired;
                end
            end
            WR0: begin
                ram_wr_d   = 1'b1;
                ram_addr_d = ram_addr_q + 19'd1;
                ram_data_d = hi_q;
                state_d    = WR1;
                if (rx_valid) begin
                    if (hold_vld_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        hold_d     = rx_data;
                        hold_vld_d = 1'b1;
                    end
                end
            end
            PIX, WR1: begin
                if (state_q == WR1) begin
                    hold_vld_d = 1'b0;
                    if (hold_vld_q && rx_valid) ovf_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
`ifdef UART_ROW_LOADER_CHECKSUM_EN
                    if (take) begin
                        go_ans = 1'b1;
                        if (take_byte == chk_q) begin
                            go_code = ACK;
                            go_done = 1'b1;
                        end
                    end else if (state_q == WR1) begin
                        state_d = PIX;
                    end else begin
                        tmo_d  = tmo_q + TW'(1);
                        go_ans = expired;
                    end
`else
                    go_ans  = 1'b1;
                    go_code = ACK;
                    go_done = 1'b1;
`endif
                end else if (take) begin
                    ram_wr_d   = 1'b1;
                    ram_addr_d = base_q + 19'({cnt_q, 1'b0});
                    ram_data_d = take_byte[2:0];
                    hi_d       = take_byte[5:3];
                    cnt_d      = cnt_q + CW'(1);
                    chk_d      = chk_q ^ take_byte;
                    state_d    = WR0;
                end else if (state_q == WR1) begin
                    state_d = PIX;
                end else begin
                    tmo_d  = tmo_q + TW'(1);
                    go_ans = expired;
                end
            end
            ANSWER: begin
                if (ans_ready) begin
                    ans_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_ans) begin
            state_d     = ANSWER;
            ans_valid_d = 1'b1;
            ans_data_d  = go_code;
            row_done_d  = go_done;
            hold_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row8_q      <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            hi_q        <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            chk_q       <= '0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ans_valid_q <= 1'b0;
            ans_data_q  <= '0;
            row_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row8_q      <= row8_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            hi_q        <= hi_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            chk_q       <= chk_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ans_valid_q <= ans_valid_d;
            ans_data_q  <= ans_data_d;
            row_done_q  <= row_done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ram_wr    = ram_wr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ans_valid = ans_valid_q;
    assign ans_data  = ans_data_q;
    assign row_done  = row_done_q;
    assign overflow  = ovf_q;

endmodule
